led_sweep_ctrl: RTL and testbench

Sequencer for an 8-bit one-hot LED sweep. On a start pulse it latches a run configuration: pattern mode, per-position dwell times for each direction, and sweep count. It then drives a one-hot `count` through bounce or wrap-around sweeps, and reports busy, progress and completion. It sits between the board's button/switch front end and the LED bank.

---
 rtl/led_sweep_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_led_sweep_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/led_sweep_ctrl.sv
// led_sweep_ctrl
// --------------
// Sequencer for a one-hot LED sweep. A start request in IDLE latches the run
// configuration (pattern mode, dwell per direction, sweep count). The block
// then walks a one-hot pattern through bounce or wrap-around sweeps and
// reports progress and completion.
//
// Ports
//   clk         in   1        single clock, all logic on posedge
//   reset       in   1        synchronous, active-high
//   start       in   1        level-sampled; begins a run when seen in IDLE
//   stop        in   1        abort; IDLE next cycle, no done pulse
//   pause       in   1        freezes count/timer/state while in UP or DOWN
//   mode        in   1        0 = bounce (up then down), 1 = wrap (up only)
//   dwell_up    in   DWELL_W  extra hold cycles per position moving up
//   dwell_down  in   DWELL_W  extra hold cycles per position moving down
//   sweeps      in   8        sweeps per run, 0 = run until stop
//   count       out  WIDTH    one-hot LED pattern
//   dir         out  1        1 = moving up, 0 = moving down
//   busy        out  1        high in UP/DOWN
//   done        out  1        one-cycle pulse on normal run completion
//   sweep_cnt   out  8        completed sweeps in current/last run
//   dbg_state   out  2        current FSM state (IDLE=0 UP=1 DOWN=2 DONE=3)
//
// Control priority, highest first: reset, stop, pause, normal stepping.
// There is no valid/ready handshake: start is a level sampled only in IDLE,
// and all outputs come straight from flops.

module led_sweep_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell_up,
    input  logic [DWELL_W-1:0] dwell_down,
    input  logic [7:0]         sweeps,
    output logic [WIDTH-1:0]   count,
    output logic               dir,
    output logic               busy,
    output logic               done,
    output logic [7:0]         sweep_cnt,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic                 dir_q, dir_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [7:0]           sweep_cnt_q, sweep_cnt_d;
    logic [DWELL_W-1:0]   timer_q, timer_d;

    // Run configuration captured when a run starts.
    logic                 cfg_mode_q;
    logic [DWELL_W-1:0]   cfg_dup_q;
    logic [DWELL_W-1:0]   cfg_ddown_q;
    logic [7:0]           cfg_sweeps_q;
    logic                 load_cfg;

    logic [DWELL_W-1:0]   dwell_cur;
    logic [7:0]           sweep_next;
    logic                 sweep_complete;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        dir_d          = dir_q;
        timer_d        = timer_q;
        sweep_cnt_d    = sweep_cnt_q;
        load_cfg       = 1'b0;
        sweep_complete = 1'b0;
        dwell_cur      = (state_q == S_DOWN) ? cfg_ddown_q : cfg_dup_q;
        sweep_next     = sweep_cnt_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                count_d = ONE;
                dir_d   = 1'b1;
                timer_d = '0;
                if (start && !stop) begin
                    state_d     = S_UP;
                    sweep_cnt_d = 8'd0;
                    load_cfg    = 1'b1;
                end
            end

            S_UP, S_DOWN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    count_d = ONE;
                    dir_d   = 1'b1;
                    timer_d = '0;
                end else if (pause) begin
                    // hold everything
                end else if (timer_q != dwell_cur) begin
                    timer_d = timer_q + 1'b1;
                end else begin
                    timer_d = '0;
                    if (state_q == S_UP) begin
                        if (count_q != MSB) begin
                            count_d = count_q << 1;
                        end else if (!cfg_mode_q) begin
                            // MSB is shown again for one cycle on DOWN entry
                            state_d = S_DOWN;
                            dir_d   = 1'b0;
                        end else begin
                            sweep_complete = 1'b1;
                        end
                    end else begin
                        if (count_q != ONE) begin
                            count_d = count_q >> 1;
                        end else begin
                            sweep_complete = 1'b1;
                        end
                    end

                    if (sweep_complete) begin
                        sweep_cnt_d = sweep_next;
                        count_d     = ONE;
                        dir_d       = 1'b1;
                        if ((cfg_sweeps_q != 8'd0) && (sweep_next == cfg_sweeps_q)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_UP;
                        end
                    end
                end
            end

            S_DONE: begin
                // stop here lands in IDLE as well, so both paths agree
                state_d = S_IDLE;
                count_d = ONE;
                dir_d   = 1'b1;
                timer_d = '0;
            end

            default: begin
                state_d = S_IDLE;
                count_d = ONE;
                dir_d   = 1'b1;
                timer_d = '0;
            end
        endcase

        busy_d = (state_d == S_UP) || (state_d == S_DOWN);
        done_d = (state_d == S_DONE);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= ONE;
            dir_q        <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sweep_cnt_q  <= 8'd0;
            timer_q      <= '0;
            cfg_mode_q   <= 1'b0;
            cfg_dup_q    <= '0;
            cfg_ddown_q  <= '0;
            cfg_sweeps_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sweep_cnt_q <= sweep_cnt_d;
            timer_q     <= timer_d;
            if (load_cfg) begin
                cfg_mode_q   <= mode;
                cfg_dup_q    <= dwell_up;
                cfg_ddown_q  <= dwell_down;
                cfg_sweeps_q <= sweeps;
            end
        end
    end

    assign count     = count_q;
    assign dir       = dir_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sweep_cnt = sweep_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Directed bench for led_sweep_ctrl (WIDTH=8, DWELL_W=4).
// Cycle numbering: the edge that samples start is edge 0; the cycle after it
// is cycle 1. Outputs are sampled 1 time unit after each rising edge.

module tb_led_sweep_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic       mode;
    logic [3:0] dwell_up;
    logic [3:0] dwell_down;
    logic [7:0] sweeps;
    logic [7:0] count;
    logic       dir;
    logic       busy;
    logic       done;
    logic [7:0] sweep_cnt;
    logic [1:0] dbg_state;

    int checks;
    int failures;
    int done_seen;

    led_sweep_ctrl #(
        .WIDTH   (8),
        .DWELL_W (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .mode       (mode),
        .dwell_up   (dwell_up),
        .dwell_down (dwell_down),
        .sweeps     (sweeps),
        .count      (count),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .sweep_cnt  (sweep_cnt),
        .dbg_state  (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise start for one edge (edge 0); returns in cycle 1.
    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] e;
        checks    = 0;
        failures  = 0;
        done_seen = 0;
        reset      = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        pause      = 1'b0;
        mode       = 1'b0;
        dwell_up   = 4'd0;
        dwell_down = 4'd0;
        sweeps     = 8'd0;
        tick();
        tick();
        reset = 1'b0;

        // ---- reset state
        chk("rst_count", count, 1);
        chk("rst_dir", dir, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sweep_cnt", sweep_cnt, 0);
        chk("rst_state", dbg_state, 0);

        // ---- bounce, Dup=3 Ddown=0 sweeps=1; start retrigger and
        //      dwell_up change mid-run must be ignored
        mode = 1'b0; dwell_up = 4'd3; dwell_down = 4'd0; sweeps = 8'd1;
        start_run();
        for (int c = 1; c <= 40; c++) begin
            if (c <= 32) e = 32'd1 << ((c - 1) / 4);
            else         e = 32'd128 >> (c - 33);
            chk("bounce_count", count, e);
            chk("bounce_busy", busy, 1);
            chk("bounce_dir", dir, (c <= 32) ? 1 : 0);
            if (c == 2) begin
                dwell_up = 4'd0;
                start    = 1'b1;
            end
            if (c == 3) start = 1'b0;
            tick();
        end
        chk("bounce_done", done, 1);
        chk("bounce_done_busy", busy, 0);
        chk("bounce_done_cnt", sweep_cnt, 1);
        chk("bounce_done_count", count, 1);
        chk("bounce_done_state", dbg_state, 3);
        tick();
        chk("bounce_idle_done", done, 0);
        chk("bounce_idle_state", dbg_state, 0);
        chk("bounce_idle_hold_cnt", sweep_cnt, 1);

        // ---- wrap, Dup=0 sweeps=2
        mode = 1'b1; dwell_up = 4'd0; dwell_down = 4'd5; sweeps = 8'd2;
        start_run();
        for (int c = 1; c <= 16; c++) begin
            chk("wrap_count", count, 32'd1 << ((c - 1) % 8));
            chk("wrap_dir", dir, 1);
            chk("wrap_done_low", done, 0);
            if (c == 1) chk("wrap_cnt_cleared", sweep_cnt, 0);
            if (c == 9) chk("wrap_cnt_mid", sweep_cnt, 1);
            tick();
        end
        chk("wrap_done", done, 1);
        chk("wrap_done_busy", busy, 0);
        chk("wrap_done_cnt", sweep_cnt, 2);
        tick();

        // ---- endless bounce (sweeps=0), sweep_cnt wrap, then stop
        mode = 1'b0; dwell_up = 4'd0; dwell_down = 4'd0; sweeps = 8'd0;
        start_run();
        for (int c = 1; c <= 4120; c++) begin
            if (done) done_seen++;
            if (c == 17)   chk("endless_cnt_1", sweep_cnt, 1);
            if (c == 4081) chk("endless_cnt_255", sweep_cnt, 255);
            if (c == 4097) chk("endless_cnt_wrap", sweep_cnt, 0);
            if (c == 4113) chk("endless_cnt_after_wrap", sweep_cnt, 1);
            if (c == 4120) begin
                chk("endless_pre_stop_count", count, 128);
                stop = 1'b1;
            end
            tick();
        end
        stop = 1'b0;
        chk("endless_no_done", done_seen, 0);
        chk("stop_count", count, 1);
        chk("stop_dir", dir, 1);
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
        chk("stop_hold_cnt", sweep_cnt, 1);
        chk("stop_state", dbg_state, 0);
        tick();
        chk("stop_no_done_later", done, 0);

        // ---- reset in the middle of DOWN
        start_run();
        for (int c = 1; c <= 26; c++) begin
            if (c == 17) chk("rstmid_cnt", sweep_cnt, 1);
            tick();
        end
        chk("rstmid_pre_dir", dir, 0);
        chk("rstmid_pre_count", count, 32);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid_count", count, 1);
        chk("rstmid_dir", dir, 1);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_sweep_cnt", sweep_cnt, 0);
        chk("rstmid_state", dbg_state, 0);

        // ---- pause 5 cycles mid-UP: bounce Dup=1 Ddown=0, done moves 25 -> 30
        mode = 1'b0; dwell_up = 4'd1; dwell_down = 4'd0; sweeps = 8'd1;
        start_run();
        for (int c = 1; c <= 30; c++) begin
            if (c >= 5 && c <= 11) chk("pause_frozen_count", count, 4);
            if (c == 12) chk("pause_resume_count", count, 8);
            if (c == 25) chk("pause_no_early_done", done, 0);
            if (c == 29) begin
                chk("pause_last_done", done, 0);
                chk("pause_last_busy", busy, 1);
            end
            if (c == 30) begin
                chk("pause_done", done, 1);
                chk("pause_done_busy", busy, 0);
            end
            pause = (c >= 5 && c <= 9);
            tick();
        end
        chk("pause_idle_state", dbg_state, 0);

        // ---- start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", busy, 0);
        chk("startstop_state", dbg_state, 0);
        tick();
        chk("startstop_busy_later", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
